// File: rtl/apb_bus_arbiter.sv
// apb_bus_arbiter: two-requester round-robin arbiter fused with an APB3 master.
// Decodes four slave slots, runs SETUP/ACCESS and bounds each access with a watchdog.
module apb_bus_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter logic [31:0] SLOT_SIZE = 32'h0000_1000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        m0_transfer,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    output logic        m0_err,
    input  logic        m1_transfer,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        m1_err,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PENABLE,
    output logic        PSEL0,
    output logic        PSEL1,
    output logic        PSEL2,
    output logic        PSEL3,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic        PREADY0,
    input  logic        PREADY1,
    input  logic        PREADY2,
    input  logic        PREADY3
);

    localparam int             SHIFT   = $clog2(SLOT_SIZE);
    localparam logic [31:0]    SPAN    = SLOT_SIZE << 2;
    localparam int             WDW     = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [31:0]    TO_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t         state;
    logic [3:0]     psel_q;
    logic [1:0]     slot_q;
    logic           mapped_q;
    logic           owner_q;
    logic           last_grant;
    logic [WDW-1:0] wd_q;
    logic [31:0]    rdata_q0;
    logic [31:0]    rdata_q1;

    logic           win;
    logic [31:0]    g_addr;
    logic [31:0]    g_wdata;
    logic           g_write;
    logic [31:0]    g_off;
    logic           g_mapped;
    logic [1:0]     g_slot;

    logic           sel_ready;
    logic [31:0]    sel_rdata;
    logic           done;
    logic           done_err;
    logic [31:0]    done_rdata;

    // Round-robin winner selection and address decode of the winning request
    always_comb begin
        win = 1'b0;
        if (m0_transfer && m1_transfer) begin
            win = ~last_grant;
        end else if (m1_transfer) begin
            win = 1'b1;
        end
        g_addr   = win ? m1_addr  : m0_addr;
        g_wdata  = win ? m1_wdata : m0_wdata;
        g_write  = win ? m1_write : m0_write;
        g_off    = g_addr - BASE_ADDR;
        g_mapped = (g_addr >= BASE_ADDR) && (g_off < SPAN);
        g_slot   = 2'(g_off >> SHIFT);
    end

    // Pick ready/rdata of the granted slot; other slots are ignored
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        unique case (slot_q)
            2'd0: begin sel_ready = PREADY0; sel_rdata = PRDATA0; end
            2'd1: begin sel_ready = PREADY1; sel_rdata = PRDATA1; end
            2'd2: begin sel_ready = PREADY2; sel_rdata = PRDATA2; end
            2'd3: begin sel_ready = PREADY3; sel_rdata = PRDATA3; end
        endcase
    end

    // Completion: unmapped first, then slave ready, then watchdog expiry
    always_comb begin
        done       = 1'b0;
        done_err   = 1'b0;
        done_rdata = '0;
        if (state == ACCESS) begin
            if (!mapped_q) begin
                done     = 1'b1;
                done_err = 1'b1;
            end else if (sel_ready) begin
                done       = 1'b1;
                done_rdata = sel_rdata;
            end else if (wd_q == WD_LAST) begin
                done       = 1'b1;
                done_err   = 1'b1;
                done_rdata = TO_DATA;
            end
        end
    end

    assign m0_ready = done & ~owner_q;
    assign m1_ready = done &  owner_q;
    assign m0_err   = done_err & m0_ready;
    assign m1_err   = done_err & m1_ready;
    assign m0_rdata = m0_ready ? done_rdata : rdata_q0;
    assign m1_rdata = m1_ready ? done_rdata : rdata_q1;

    assign PSEL0 = psel_q[0];
    assign PSEL1 = psel_q[1];
    assign PSEL2 = psel_q[2];
    assign PSEL3 = psel_q[3];

    // Transfer FSM with registered APB outputs, grant history and watchdog
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state      <= IDLE;
            PADDR      <= '0;
            PWDATA     <= '0;
            PWRITE     <= 1'b0;
            PENABLE    <= 1'b0;
            psel_q     <= '0;
            slot_q     <= '0;
            mapped_q   <= 1'b0;
            owner_q    <= 1'b0;
            last_grant <= 1'b1;
            wd_q       <= '0;
            rdata_q0   <= '0;
            rdata_q1   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (m0_transfer || m1_transfer) begin
                        PADDR      <= g_addr;
                        PWDATA     <= g_wdata;
                        PWRITE     <= g_write;
                        slot_q     <= g_slot;
                        mapped_q   <= g_mapped;
                        owner_q    <= win;
                        last_grant <= win;
                        psel_q     <= g_mapped ? (4'b0001 << g_slot) : 4'b0000;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    wd_q    <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        psel_q  <= '0;
                        PENABLE <= 1'b0;
                        state   <= IDLE;
                        if (owner_q) begin
                            rdata_q1 <= done_rdata;
                        end else begin
                            rdata_q0 <= done_rdata;
                        end
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// tb_apb_bus_arbiter: table vectors, contention/reset sequences and random
// transfers compared against a transaction-level model of the arbiter.
module tb_apb_bus_arbiter;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] SIZE = 32'h0000_1000;
    localparam int          TO   = 16;

    typedef struct {
        bit          t0;
        bit          t1;
        bit          w0;
        bit          w1;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] d0;
        logic [31:0] d1;
        int          wt;
        bit          e_own;
        logic [3:0]  e_psel;
        int          e_cyc;
        bit          e_err;
        logic [31:0] e_rdata;
    } vec_t;

    logic        PCLK;
    logic        PRESET;
    logic        m0_transfer, m0_write, m1_transfer, m1_write;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    wire  [31:0] m0_rdata, m1_rdata;
    wire         m0_ready, m0_err, m1_ready, m1_err;
    wire  [31:0] PADDR, PWDATA;
    wire         PWRITE, PENABLE;
    wire  [3:0]  psel;
    logic [31:0] pd [4];
    logic [3:0]  pready;

    int          checks;
    int          failures;
    bit          mlast;
    logic [31:0] hold [2];

    apb_bus_arbiter dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .m0_transfer (m0_transfer),
        .m0_write    (m0_write),
        .m0_addr     (m0_addr),
        .m0_wdata    (m0_wdata),
        .m0_rdata    (m0_rdata),
        .m0_ready    (m0_ready),
        .m0_err      (m0_err),
        .m1_transfer (m1_transfer),
        .m1_write    (m1_write),
        .m1_addr     (m1_addr),
        .m1_wdata    (m1_wdata),
        .m1_rdata    (m1_rdata),
        .m1_ready    (m1_ready),
        .m1_err      (m1_err),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PWRITE      (PWRITE),
        .PENABLE     (PENABLE),
        .PSEL0       (psel[0]),
        .PSEL1       (psel[1]),
        .PSEL2       (psel[2]),
        .PSEL3       (psel[3]),
        .PRDATA0     (pd[0]),
        .PRDATA1     (pd[1]),
        .PRDATA2     (pd[2]),
        .PRDATA3     (pd[3]),
        .PREADY0     (pready[0]),
        .PREADY1     (pready[1]),
        .PREADY2     (pready[2]),
        .PREADY3     (pready[3])
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(input bit t0, input bit t1, input bit w0, input bit w1,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input int wt, input bit own, input logic [3:0] ps,
                                 input int cyc, input bit err, input logic [31:0] rd);
        vec_t v;
        v.t0 = t0; v.t1 = t1; v.w0 = w0; v.w1 = w1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.wt = wt; v.e_own = own; v.e_psel = ps;
        v.e_cyc = cyc; v.e_err = err; v.e_rdata = rd;
        return v;
    endfunction

    // Transaction-level expectation: who wins, which slot, how long, what result
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        logic [31:0] a;
        bit          mapped;
        int          slot;
        r = v;
        r.e_own = (v.t0 && v.t1) ? !mlast : v.t1;
        a = r.e_own ? v.a1 : v.a0;
        mapped = (a >= BASE) && ((a - BASE) < 4 * SIZE);
        slot = int'((a - BASE) / SIZE);
        r.e_psel = mapped ? 4'(1 << slot) : 4'b0000;
        if (!mapped) begin
            r.e_cyc = 1; r.e_err = 1'b1; r.e_rdata = 32'h0;
        end else if (v.wt < TO) begin
            r.e_cyc = v.wt + 1; r.e_err = 1'b0; r.e_rdata = pd[slot];
        end else begin
            r.e_cyc = TO; r.e_err = 1'b1; r.e_rdata = 32'hDEAD_BEEF;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        int c;
        c = int'($urandom_range(0, 9));
        if (c < 7)
            return BASE + SIZE * 32'($urandom_range(0, 3)) + 32'(4 * $urandom_range(0, 1023));
        else if (c == 7)
            return BASE - 32'(4 * $urandom_range(1, 1000));
        else if (c == 8)
            return BASE + 4 * SIZE + 32'(4 * $urandom_range(0, 1000));
        return $urandom;
    endfunction

    task automatic do_reset();
        @(negedge PCLK);
        m0_transfer = 1'b0; m1_transfer = 1'b0; pready = 4'h0;
        PRESET = 1'b0;
        #1;
        chk("rst_psel", {28'h0, psel}, 32'h0);
        chk("rst_penable", {31'h0, PENABLE}, 32'h0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_pwrite", {31'h0, PWRITE}, 32'h0);
        chk("rst_ready", {28'h0, m0_ready, m0_err, m1_ready, m1_err}, 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b1;
        mlast = 1'b1;
        hold[0] = 32'h0;
        hold[1] = 32'h0;
    endtask

    // One arbitration round starting in an IDLE cycle
    task automatic run_xfer(input vec_t v);
        logic [31:0] ea, ed;
        bit          ew, done;
        int          s;
        ea = v.e_own ? v.a1 : v.a0;
        ed = v.e_own ? v.d1 : v.d0;
        ew = v.e_own ? v.w1 : v.w0;
        s = -1;
        for (int i = 0; i < 4; i++) if (v.e_psel[i]) s = i;
        @(negedge PCLK);
        m0_transfer = v.t0; m0_write = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
        m1_transfer = v.t1; m1_write = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
        pready = 4'h0;
        #1;
        chk("idle_psel", {28'h0, psel}, 32'h0);
        chk("idle_penable", {31'h0, PENABLE}, 32'h0);
        @(negedge PCLK);
        #1;
        chk("setup_psel", {28'h0, psel}, {28'h0, v.e_psel});
        chk("setup_penable", {31'h0, PENABLE}, 32'h0);
        chk("setup_paddr", PADDR, ea);
        chk("setup_ready", {30'h0, m0_ready, m1_ready}, 32'h0);
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge PCLK);
            pready = 4'hF;
            if (s >= 0 && k < v.wt) pready[s] = 1'b0;
            #1;
            chk("acc_psel", {28'h0, psel}, {28'h0, v.e_psel});
            chk("acc_penable", {31'h0, PENABLE}, 32'h1);
            chk("acc_paddr", PADDR, ea);
            chk("acc_pwdata", PWDATA, ed);
            chk("acc_pwrite", {31'h0, PWRITE}, {31'h0, ew});
            if (v.e_own) chk("loser_m0", {30'h0, m0_ready, m0_err}, 32'h0);
            else         chk("loser_m1", {30'h0, m1_ready, m1_err}, 32'h0);
            if (v.e_own ? m1_ready : m0_ready) begin
                done = 1'b1;
                chk("latency", 32'(k + 1), 32'(v.e_cyc));
                chk("err", {31'h0, v.e_own ? m1_err : m0_err}, {31'h0, v.e_err});
                chk("rdata", v.e_own ? m1_rdata : m0_rdata, v.e_rdata);
            end
        end
        if (!done) chk("ready_timeout", {31'h0, v.e_own ? m1_ready : m0_ready}, 32'h1);
        @(negedge PCLK);
        m0_transfer = 1'b0; m1_transfer = 1'b0; pready = 4'h0;
        #1;
        chk("post_psel", {28'h0, psel}, 32'h0);
        chk("post_penable", {31'h0, PENABLE}, 32'h0);
        chk("hold_own", v.e_own ? m1_rdata : m0_rdata, v.e_rdata);
        chk("hold_other", v.e_own ? m0_rdata : m1_rdata, hold[v.e_own ? 0 : 1]);
        hold[v.e_own ? 1 : 0] = v.e_rdata;
        mlast = v.e_own;
    endtask

    vec_t        tbl [8];
    vec_t        v;
    logic [1:0]  rq;
    bit          er;
    int          eo;

    initial begin
        checks = 0; failures = 0;
        PRESET = 1'b0;
        m0_transfer = 0; m0_write = 0; m0_addr = '0; m0_wdata = '0;
        m1_transfer = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0;
        pready = 4'h0;
        for (int i = 0; i < 4; i++) pd[i] = 32'hC0DE_0000 + 32'(i);

        tbl[0] = mkv(1, 0, 0, 0, 32'h1000_0004, 32'h0, 32'h0, 32'h0, 0,
                     0, 4'b0001, 1, 0, 32'hC0DE_0000);
        tbl[1] = mkv(0, 1, 0, 1, 32'h0, 32'h1000_1000, 32'h0, 32'hA5, 3,
                     1, 4'b0010, 4, 0, 32'hC0DE_0001);
        tbl[2] = mkv(1, 0, 0, 0, 32'h2000_0000, 32'h0, 32'h0, 32'h0, 0,
                     0, 4'b0000, 1, 1, 32'h0);
        tbl[3] = mkv(1, 0, 0, 0, 32'h1000_2000, 32'h0, 32'h0, 32'h0, 99,
                     0, 4'b0100, 16, 1, 32'hDEAD_BEEF);
        tbl[4] = mkv(1, 1, 1, 0, 32'h1000_0000, 32'h1000_3FFC, 32'h1111, 32'h0, 15,
                     1, 4'b1000, 16, 0, 32'hC0DE_0003);
        tbl[5] = mkv(1, 1, 0, 1, 32'h1000_4000, 32'h1000_1004, 32'h0, 32'h2222, 0,
                     0, 4'b0000, 1, 1, 32'h0);
        tbl[6] = mkv(0, 1, 0, 0, 32'h0, 32'h0FFF_FFFC, 32'h0, 32'h0, 0,
                     1, 4'b0000, 1, 1, 32'h0);
        tbl[7] = mkv(1, 0, 1, 0, 32'h1000_0FFF, 32'h0, 32'hFEED, 32'h0, 2,
                     0, 4'b0001, 3, 0, 32'hC0DE_0000);

        do_reset();
        for (int i = 0; i < 8; i++) run_xfer(tbl[i]);

        // Both requesters hold transfer from reset: alternate grants every 3 cycles
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge PCLK);
            m0_transfer = 1'b1; m0_write = 1'b0; m0_addr = 32'h1000_0010;
            m1_transfer = 1'b1; m1_write = 1'b0; m1_addr = 32'h1000_1020;
            pready = 4'hF;
            #1;
            er = (c % 3) == 2;
            eo = (c / 3) % 2;
            chk("rr_m0_ready", {31'h0, m0_ready}, {31'h0, er && eo == 0});
            chk("rr_m1_ready", {31'h0, m1_ready}, {31'h0, er && eo == 1});
            chk("rr_psel", {28'h0, psel},
                (c % 3) == 0 ? 32'h0 : (eo == 1 ? 32'h2 : 32'h1));
            if (er) chk("rr_rdata", eo == 1 ? m1_rdata : m0_rdata, pd[eo]);
        end
        @(negedge PCLK);
        m0_transfer = 1'b0; m1_transfer = 1'b0; pready = 4'h0;

        // Reset asserted in the middle of a stalled access
        @(negedge PCLK);
        m0_transfer = 1'b1; m0_addr = 32'h1000_2000;
        @(negedge PCLK);
        @(negedge PCLK);
        @(negedge PCLK);
        #1;
        chk("mid_penable", {31'h0, PENABLE}, 32'h1);
        #1;
        PRESET = 1'b0;
        #1;
        chk("mid_rst_psel", {28'h0, psel}, 32'h0);
        chk("mid_rst_penable", {31'h0, PENABLE}, 32'h0);
        chk("mid_rst_ready", {30'h0, m0_ready, m0_err}, 32'h0);
        @(negedge PCLK);
        m0_transfer = 1'b0;
        PRESET = 1'b1;
        mlast = 1'b1;
        hold[0] = 32'h0;
        hold[1] = 32'h0;
        run_xfer(model(mkv(1, 1, 0, 0, 32'h1000_1008, 32'h1000_2008, 32'h0, 32'h0,
                           1, 0, 4'h0, 0, 0, 32'h0)));

        // Random transfers against the transaction model
        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < 4; i++) pd[i] = $urandom;
            rq = 2'($urandom_range(1, 3));
            v = mkv(rq[0], rq[1], 1'($urandom), 1'($urandom),
                    rand_addr(), rand_addr(), $urandom, $urandom,
                    int'($urandom_range(0, 20)), 0, 4'h0, 0, 0, 32'h0);
            run_xfer(model(v));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
